// File: rtl/shift_add_multiplier_4bits_pkg.sv
// Shared types and helpers for the shift-and-add multiplier slice.
// Holds the controller state encoding, the default operand width and a clog2 helper.
package shift_add_multiplier_4bits_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } stateT;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    while ((32'd1 << result) < value) result++;
    return result;
  endfunction

endpackage

// File: rtl/shift_add_multiplier_4bits_adder.sv
// Purely combinational WIDTH-bit ripple-carry adder made of chained full-adder cells.
module ripple_carry_adder_n #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CarryIn,
  output logic [WIDTH-1:0] Sum,
  output logic             CarryOut
);

  logic [WIDTH:0] carry;

  assign carry[0] = CarryIn;

  for (genvar i = 0; i < WIDTH; i++) begin : gFullAdder
    assign Sum[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i + 1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign CarryOut = carry[WIDTH];

endmodule

// File: rtl/shift_add_multiplier_4bits.sv
// Iterative unsigned shift-and-add multiplier: one add-and-shift step per clock,
// WIDTH steps per product, with a Start/Busy/Done handshake and a registered Product.
module shift_add_multiplier_4bits
  import shift_add_multiplier_4bits_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 Busy,
  output logic                 Done,
  output logic [2*WIDTH-1:0]   Product
);

  localparam int unsigned CW = clog2(WIDTH + 1);

  stateT            state, nextState;
  logic [WIDTH-1:0] m, q, acc;
  logic [CW-1:0]    count;

  logic [WIDTH-1:0]   sum;
  logic               carryOut;
  logic               stepCarry;
  logic [WIDTH-1:0]   stepAcc;
  logic [2*WIDTH-1:0] shifted;
  logic               accept;
  logic               lastStep;

  ripple_carry_adder_n #(.WIDTH(WIDTH)) uAdder (
    .A        (acc),
    .B        (m),
    .CarryIn  (1'b0),
    .Sum      (sum),
    .CarryOut (carryOut)
  );

  // C is consumed by the shift in the same cycle it is produced, so after every
  // step it is zero again; it lives only as stepCarry rather than a register.
  always_comb begin
    stepCarry = 1'b0;
    stepAcc   = acc;
    if (q[0]) begin
      stepCarry = carryOut;
      stepAcc   = sum;
    end
    shifted  = {stepCarry, stepAcc, q[WIDTH-1:1]};
    accept   = Start && ((state == IDLE) || (state == DONE));
    lastStep = (count == CW'(WIDTH - 1));
  end

  always_ff @(posedge Clock) begin
    if (Reset) state <= IDLE;
    else       state <= nextState;
  end

  always_comb begin
    nextState = IDLE;
    case (state)
      IDLE:    nextState = Start ? RUN : IDLE;
      RUN:     nextState = lastStep ? DONE : RUN;
      DONE:    nextState = Start ? RUN : IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_comb begin
    Busy = (state == RUN);
    Done = (state == DONE);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      m       <= '0;
      q       <= '0;
      acc     <= '0;
      count   <= '0;
      Product <= '0;
    end else if (accept) begin
      m     <= A;
      q     <= B;
      acc   <= '0;
      count <= '0;
    end else if (state == RUN) begin
      acc   <= shifted[2*WIDTH-1:WIDTH];
      q     <= shifted[WIDTH-1:0];
      count <= count + CW'(1);
      if (lastStep) Product <= shifted;
    end
  end

endmodule

// File: tb/tb_shift_add_multiplier_4bits.sv
// Self-checking bench for shift_add_multiplier_4bits against a plain a*b reference.
module tb_shift_add_multiplier_4bits;

  logic       Clock = 1'b0;
  logic       Reset = 1'b1;
  logic       Start = 1'b0;
  logic [3:0] A = '0;
  logic [3:0] B = '0;
  logic       Busy;
  logic       Done;
  logic [7:0] Product;

  int unsigned passed = 0;
  int unsigned total  = 0;
  logic [7:0]  expProduct = '0;

  shift_add_multiplier_4bits #(.WIDTH(4)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Start   (Start),
    .A       (A),
    .B       (B),
    .Busy    (Busy),
    .Done    (Done),
    .Product (Product)
  );

  always #5 Clock = ~Clock;

  // Starts a product from IDLE or DONE; returns at the negedge of the Done cycle.
  task automatic mulOp(input logic [3:0] a, input logic [3:0] b, input bit forceStart,
                       input string tag);
    logic [7:0] want;
    want  = {4'b0, a} * {4'b0, b};
    A     = a;
    B     = b;
    Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (Busy !== 1'b1 || Done !== 1'b0 || Product !== expProduct) begin
        $display("FAIL %s run%0d %0d*%0d: Busy=%b Done=%b Product=%h, required Busy=1 Done=0 Product=%h",
                 tag, i, a, b, Busy, Done, Product, expProduct);
      end else passed++;
      A     = 4'($urandom);
      B     = 4'($urandom);
      Start = forceStart ? 1'b1 : 1'($urandom);
      @(posedge Clock);
      @(negedge Clock);
    end
    expProduct = want;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b1 || Product !== want) begin
      $display("FAIL %s done %0d*%0d: Busy=%b Done=%b Product=%h, required Busy=0 Done=1 Product=%h",
               tag, a, b, Busy, Done, Product, want);
    end else passed++;
  endtask

  task automatic idleCycle(input string tag);
    Start = 1'b0;
    @(posedge Clock);
    @(negedge Clock);
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Product !== expProduct) begin
      $display("FAIL %s idle: Busy=%b Done=%b Product=%h, required Busy=0 Done=0 Product=%h",
               tag, Busy, Done, Product, expProduct);
    end else passed++;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    Start = 1'b1;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    expProduct = '0;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 8'h00) begin
      $display("FAIL reset: Busy=%b Done=%b Product=%h, required 0 0 00", Busy, Done, Product);
    end else passed++;
    Reset = 1'b0;
    idleCycle("reset");
  endtask

  task automatic test_basic();
    mulOp(4'd13, 4'd11, 1'b0, "basic13x11");
    idleCycle("basic13x11");
    mulOp(4'd15, 4'd15, 1'b0, "carry15x15");
    idleCycle("carry15x15");
  endtask

  task automatic test_zero_one();
    mulOp(4'd0, 4'd9, 1'b0, "zero0x9");
    idleCycle("zero0x9");
    mulOp(4'd1, 4'd9, 1'b0, "one1x9");
    idleCycle("one1x9");
    mulOp(4'd9, 4'd0, 1'b0, "zero9x0");
    idleCycle("zero9x0");
  endtask

  task automatic test_back_to_back();
    mulOp(4'd3, 4'd5, 1'b1, "b2b3x5");
    mulOp(4'd7, 4'd7, 1'b1, "b2b7x7");
    mulOp(4'd15, 4'd2, 1'b1, "b2b15x2");
    idleCycle("b2b");
  endtask

  task automatic test_reset_mid_run();
    A     = 4'd12;
    B     = 4'd12;
    Start = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Start = 1'b0;
    total++;
    if (Busy !== 1'b1) $display("FAIL midreset run1: Busy=%b, required 1", Busy);
    else passed++;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    expProduct = '0;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0 || Product !== 8'h00) begin
      $display("FAIL midreset clear: Busy=%b Done=%b Product=%h, required 0 0 00",
               Busy, Done, Product);
    end else passed++;
    for (int i = 0; i < 6; i++) idleCycle("midreset");
    mulOp(4'd2, 4'd3, 1'b0, "after2x3");
    idleCycle("after2x3");
  endtask

  task automatic test_sweep();
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        mulOp(4'(a), 4'(b), 1'b0, "sweep");
        if ($urandom_range(0, 1) == 0) idleCycle("sweep");
      end
    end
    idleCycle("sweep");
  endtask

  initial begin
    @(negedge Clock);
    test_reset();
    test_basic();
    test_zero_one();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
